// File: rtl/encoder_sampler.sv
// Snapshot controller for a bank of quadrature encoder counters: latches every count at once,
// forms per-channel deltas through one shared subtractor and publishes them to a read bank.
module encoder_sampler #(
    parameter int NUM_ENC = 5,
    parameter int CNT_W   = 16,
    parameter int PERIOD  = 18432
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_ENC*CNT_W-1:0] counts,
    input  logic                     sample_now,
    input  logic                     rd_en,
    input  logic [2:0]               rd_idx,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     ack,
    output logic                     sample_ready,
    output logic                     data_pending,
    output logic                     overrun,
    output logic                     busy
);
    localparam int TW = $clog2(PERIOD);

    typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_CALC, ST_PUBLISH} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         ch_q, ch_d;
    logic               primed_q, primed_d;
    logic [CNT_W-1:0]   snap_q      [NUM_ENC];
    logic [CNT_W-1:0]   snap_d      [NUM_ENC];
    logic [CNT_W-1:0]   prev_q      [NUM_ENC];
    logic [CNT_W-1:0]   prev_d      [NUM_ENC];
    logic [CNT_W-1:0]   staged_q    [NUM_ENC];
    logic [CNT_W-1:0]   staged_d    [NUM_ENC];
    logic [CNT_W-1:0]   published_q [NUM_ENC];
    logic [CNT_W-1:0]   published_d [NUM_ENC];
    logic [CNT_W-1:0]   cnt_in      [NUM_ENC];
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               data_pending_q, data_pending_d;
    logic               overrun_q, overrun_d;
    logic               tick;
    logic               trigger;
    logic               publish;

    for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_unpack
        assign cnt_in[gi] = counts[gi*CNT_W +: CNT_W];
    end

    assign tick    = (timer_q == TW'(PERIOD - 1));
    assign trigger = enable && (tick || sample_now) && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (trigger) state_d = ST_SNAP;
            ST_SNAP:    state_d = ST_CALC;
            ST_CALC:    if (ch_q == 3'(NUM_ENC - 1)) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        publish = (state_q == ST_PUBLISH) && primed_q;
    end

    always_comb begin
        timer_d        = timer_q;
        ch_d           = ch_q;
        primed_d       = primed_q;
        snap_d         = snap_q;
        prev_d         = prev_q;
        staged_d       = staged_q;
        published_d    = published_q;
        data_pending_d = data_pending_q;
        overrun_d      = overrun_q;
        rd_valid_d     = rd_en;
        rd_data_d      = rd_data_q;

        // Only an accepted forced request restarts the period; a dropped one leaves it alone.
        if (!enable || tick || (trigger && sample_now)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_SNAP: begin
                snap_d = cnt_in;
                ch_d   = '0;
            end
            ST_CALC: begin
                for (int i = 0; i < NUM_ENC; i++) begin
                    if (ch_q == 3'(i)) begin
                        staged_d[i] = snap_q[i] - prev_q[i];
                        prev_d[i]   = snap_q[i];
                    end
                end
                ch_d = ch_q + 1'b1;
            end
            ST_PUBLISH: begin
                // The first pass after reset only seeds prev; its deltas would measure from zero.
                if (primed_q) begin
                    published_d = staged_q;
                end else begin
                    primed_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (ack) begin
            data_pending_d = 1'b0;
            overrun_d      = 1'b0;
        end
        if (publish) begin
            data_pending_d = 1'b1;
            if (data_pending_q && !ack) begin
                overrun_d = 1'b1;
            end
        end

        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_ENC; i++) begin
                if (rd_idx == 3'(i)) begin
                    rd_data_d = published_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q        <= '0;
            ch_q           <= '0;
            primed_q       <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            data_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            for (int i = 0; i < NUM_ENC; i++) begin
                snap_q[i]      <= '0;
                prev_q[i]      <= '0;
                staged_q[i]    <= '0;
                published_q[i] <= '0;
            end
        end else begin
            timer_q        <= timer_d;
            ch_q           <= ch_d;
            primed_q       <= primed_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            data_pending_q <= data_pending_d;
            overrun_q      <= overrun_d;
            snap_q         <= snap_d;
            prev_q         <= prev_d;
            staged_q       <= staged_d;
            published_q    <= published_d;
        end
    end

    assign sample_ready = publish;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign data_pending = data_pending_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_encoder_sampler.sv
// Directed bench for encoder_sampler: read responses go through a queue-based scoreboard,
// sequencing and status flags are checked against hand-computed values.
module tb_encoder_sampler;
    localparam int NUM_ENC = 5;
    localparam int CNT_W   = 16;
    localparam int PERIOD  = 32;

    logic                     clk;
    logic                     rst_n;
    logic                     enable;
    logic [NUM_ENC*CNT_W-1:0] counts;
    logic                     sample_now;
    logic                     rd_en;
    logic [2:0]               rd_idx;
    logic [CNT_W-1:0]         rd_data;
    logic                     rd_valid;
    logic                     ack;
    logic                     sample_ready;
    logic                     data_pending;
    logic                     overrun;
    logic                     busy;

    int               tests;
    int               fails;
    int               cyc;
    int               sr_count;
    logic [CNT_W-1:0] exp_q [$];

    encoder_sampler #(
        .NUM_ENC (NUM_ENC),
        .CNT_W   (CNT_W),
        .PERIOD  (PERIOD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .counts       (counts),
        .sample_now   (sample_now),
        .rd_en        (rd_en),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .ack          (ack),
        .sample_ready (sample_ready),
        .data_pending (data_pending),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: pops one expected read per rd_valid and counts publish pulses.
    always @(negedge clk) begin
        if (sample_ready) sr_count++;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_valid", 32'(rd_valid), 32'd0);
            end else begin
                logic [CNT_W-1:0] e;
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_read(input logic [2:0] idx, input logic [CNT_W-1:0] exp);
        rd_en  = 1'b1;
        rd_idx = idx;
        exp_q.push_back(exp);
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic chk_status(input string name, input logic dp, input logic ov);
        check({name, "_pending"}, 32'(data_pending), 32'(dp));
        check({name, "_overrun"}, 32'(overrun), 32'(ov));
    endtask

    task automatic chk_idle_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_sample_ready"}, 32'(sample_ready), 32'd0);
        check({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({name, "_rd_data"}, 32'(rd_data), 32'd0);
        chk_status(name, 1'b0, 1'b0);
    endtask

    // One sample sequence: optionally forced (enable dropped right after the trigger),
    // with optional count change after SNAP, ack on PUBLISH and a read across PUBLISH.
    task automatic run_sample(input string name, input bit forced, input bit exp_pub,
                              input int chg_ch, input logic [CNT_W-1:0] chg_val,
                              input bit ack_pub, input int prd_idx,
                              input logic [CNT_W-1:0] prd_old, input logic [CNT_W-1:0] prd_new);
        int n;
        int busy_n;
        int pub_pos;
        n = 0;
        if (forced) begin
            enable     = 1'b1;
            sample_now = 1'b1;
            step();
            sample_now = 1'b0;
            enable     = 1'b0;
        end else begin
            while (!busy && n < 64) begin
                step();
                n++;
            end
        end
        busy_n  = 0;
        pub_pos = 0;
        while (busy && busy_n < 20) begin
            busy_n++;
            if (busy_n == 2 && chg_ch >= 0) counts[chg_ch*CNT_W +: CNT_W] = chg_val;
            if (sample_ready) begin
                pub_pos = busy_n;
                ack     = ack_pub;
                if (prd_idx >= 0) begin
                    rd_en  = 1'b1;
                    rd_idx = 3'(prd_idx);
                    exp_q.push_back(prd_old);
                end
            end
            step();
            ack = 1'b0;
        end
        if (pub_pos != 0 && prd_idx >= 0) begin
            exp_q.push_back(prd_new);
            step();
        end
        rd_en = 1'b0;
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(NUM_ENC + 2));
        check({name, "_publish_pos"}, 32'(pub_pos), exp_pub ? 32'(NUM_ENC + 2) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_trig;
        int sr_before;
        int n;
        tests      = 0;
        fails      = 0;
        cyc        = 0;
        sr_count   = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        sample_now = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = 3'd0;
        ack        = 1'b0;
        counts     = {NUM_ENC{16'h0010}};
        repeat (3) step();
        rst_n = 1'b1;
        chk_idle_outputs("reset");

        // Prime on the first automatic tick, publish on the second.
        enable = 1'b1;
        repeat (31) step();
        check("prime_pre_tick_busy", 32'(busy), 32'd0);
        step();
        check("prime_tick_snap_busy", 32'(busy), 32'd1);
        run_sample("prime", 1'b0, 1'b0, -1, '0, 1'b0, -1, '0, '0);
        do_read(3'd0, 16'h0000);
        do_read(3'd4, 16'h0000);
        check("prime_pending", 32'(data_pending), 32'd0);
        counts[0*CNT_W +: CNT_W] = 16'h0025;
        run_sample("first_pub", 1'b0, 1'b1, -1, '0, 1'b0, -1, '0, '0);
        enable = 1'b0;
        chk_status("first_pub", 1'b1, 1'b0);
        do_read(3'd0, 16'h0015);
        do_read(3'd1, 16'h0000);

        // Wrap-around and negative deltas; second unacked publish sets overrun.
        counts[0*CNT_W +: CNT_W] = 16'hFFFE;
        counts[1*CNT_W +: CNT_W] = 16'h0003;
        run_sample("seed_wrap", 1'b1, 1'b1, -1, '0, 1'b0, -1, '0, '0);
        chk_status("overrun_set", 1'b1, 1'b1);
        do_read(3'd0, 16'hFFD9);
        do_read(3'd1, 16'hFFF3);
        do_read(3'd2, 16'h0000);
        do_ack();
        chk_status("ack_clear", 1'b0, 1'b0);
        do_ack();
        chk_status("ack_idle", 1'b0, 1'b0);
        counts[0*CNT_W +: CNT_W] = 16'h0003;
        counts[1*CNT_W +: CNT_W] = 16'hFFFE;
        run_sample("wrap", 1'b1, 1'b1, -1, '0, 1'b0, -1, '0, '0);
        chk_status("wrap", 1'b1, 1'b0);
        do_read(3'd0, 16'h0005);
        do_read(3'd1, 16'hFFFB);
        do_read(3'd3, 16'h0000);

        // Count 2 changes after SNAP; ack lands on PUBLISH; read straddles PUBLISH.
        counts[2*CNT_W +: CNT_W] = 16'h0100;
        run_sample("latch", 1'b1, 1'b1, 2, 16'h0200, 1'b1, 2, 16'h0000, 16'h00F0);
        chk_status("ack_on_publish", 1'b1, 1'b0);
        do_read(3'd0, 16'h0000);
        do_read(3'd1, 16'h0000);
        run_sample("latch_next", 1'b1, 1'b1, -1, '0, 1'b0, -1, '0, '0);
        chk_status("latch_next", 1'b1, 1'b1);
        do_read(3'd2, 16'h0100);
        do_ack();
        chk_status("latch_ack", 1'b0, 1'b0);

        // Out-of-range indices return zero with a valid strobe.
        do_read(3'd7, 16'h0000);
        do_read(3'd5, 16'h0000);
        do_read(3'd2, 16'h0100);

        // Forced sample at timer=10 reloads the period; a request while busy is dropped.
        enable = 1'b1;
        repeat (10) step();
        sr_before  = sr_count;
        t_trig     = cyc;
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        repeat (2) step();
        check("drop_busy", 32'(busy), 32'd1);
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("forced_pulses", 32'(sr_count - sr_before), 32'd1);
        chk_status("forced", 1'b1, 1'b0);
        counts[4*CNT_W +: CNT_W] = 16'h0030;
        n = 0;
        while (!busy && n < 60) begin
            step();
            n++;
        end
        check("tick_after_reload", 32'(cyc - t_trig), 32'(PERIOD + 1));
        enable = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("tick_pulses", 32'(sr_count - sr_before), 32'd2);
        chk_status("tick_overrun", 1'b1, 1'b1);
        do_read(3'd2, 16'h0000);
        do_read(3'd4, 16'h0020);

        // Reset in the middle of CALC clears everything and forces a re-prime.
        counts[0*CNT_W +: CNT_W] = 16'h1000;
        enable     = 1'b1;
        sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        enable     = 1'b0;
        repeat (2) step();
        check("calc_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_outputs("mid_reset");
        run_sample("reprime", 1'b1, 1'b0, -1, '0, 1'b0, -1, '0, '0);
        do_read(3'd0, 16'h0000);
        do_read(3'd4, 16'h0000);
        check("reprime_pending", 32'(data_pending), 32'd0);
        counts[0*CNT_W +: CNT_W] = 16'h1005;
        run_sample("after_reprime", 1'b1, 1'b1, -1, '0, 1'b0, -1, '0, '0);
        chk_status("after_reprime", 1'b1, 1'b0);
        do_read(3'd0, 16'h0005);
        do_read(3'd1, 16'h0000);

        repeat (2) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
